uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised successor to the board-level UART receive path.
- Contains:
  - a programmable oversample-tick generator fed by a runtime baud divisor;
  - a 2-FF input synchroniser;
  - a majority-vote oversampling receive FSM with runtime parity and 1/2 stop-bit modes;
  - a first-word-fall-through FIFO that stores per-byte parity and framing error flags.
- Sits between the board pin and any consumer: seven-segment display logic, command parser or TX loopback.

Parameters:
- DATA_BITS, 8: data bits per frame, 5..8, LSB first.
- OVERSAMPLE, 16: ticks per bit, even, >=4.
- FIFO_DEPTH, 8: entries, power of two, >=2.
- DIV_W, 16: width of baud_div.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- baud_div  in  DIV_W  clk cycles per oversample tick, minus 1.
- rx_in  in  1  asynchronous serial line, idle high.
- parity_en  in  1  1 = a parity bit follows the data bits.
- parity_odd  in  1  0 = even parity, 1 = odd parity.
- stop2  in  1  1 = two stop bits checked.
- rd_en  in  1  pop the head entry; ignored when FIFO is empty.
- clr_overrun  in  1  clears the overrun flag.
- rd_data  out  DATA_BITS  head entry data, valid when !fifo_empty.
- rd_perr  out  1  head entry parity error.
- rd_ferr  out  1  head entry framing error.
- fifo_empty  out  1
- fifo_full  out  1
- fifo_count  out  $clog2(FIFO_DEPTH)+1
- overrun  out  1  sticky; a frame was dropped because the FIFO was full.
- break_det  out  1  one-clk pulse on break detection.
- state  out  3  current FSM state, for debug LEDs.

Behaviour:
- Reset values:
  - all outputs 0, except fifo_empty=1;
  - synchroniser flops = 1, FSM = IDLE, tick counter = 0, FIFO pointers = 0.
- Tick generator:
  - counter counts 0..baud_div; tick is a 1-clk pulse when counter==baud_div, then counter wraps to 0;
  - a new baud_div value takes effect at the next wrap;
  - baud_div=0 gives a tick every clk.
- The FSM advances only on ticks. rxs is the synchronised rx_in.
- Within each bit: samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit. The bit value is the majority of the three and is decided at tick OVERSAMPLE/2+1.
- States (encoding 0..5):
  - IDLE(0): rxs==0 on a tick -> START. The tick sub-counter is cleared, so that tick is sub-count 0 of the start bit.
  - START(1): start bit voted 1 -> IDLE (glitch rejected, no FIFO write). Voted 0 -> DATA at end of bit.
  - DATA(2): shifts in DATA_BITS bits LSB first. Then -> PARITY if parity_en, else -> STOP.
  - PARITY(3): perr = parity_en & (voted bit != expected). Expected = XOR(data) ^ parity_odd.
  - STOP(4): checks one stop bit, or two when stop2=1; ferr is set if any stop bit votes 0. The FIFO write happens at the decision tick of the last stop bit, after which -> IDLE, or -> WAIT_IDLE if ferr.
  - WAIT_IDLE(5): stays until rxs==1 on a tick, then -> IDLE.
- parity_en, parity_odd and stop2 are sampled at the START->DATA transition and held for the frame.
- Break: when data==0 and the frame ends with ferr=1, break_det pulses for one clk at the write cycle. The entry is still written with ferr=1.
- FIFO:
  - entry = {ferr, perr, data};
  - FWFT: rd_data, rd_perr and rd_ferr show the head entry combinationally from the registered pointers;
  - pointers wrap modulo FIFO_DEPTH;
  - fifo_count is 0..FIFO_DEPTH.
- FIFO boundary cases:
  - Push when full with no rd_en: frame dropped, overrun <= 1, FIFO unchanged.
  - Push and rd_en in the same cycle when full: both accepted, count unchanged, no overrun.
  - rd_en when empty: no effect.
  - Simultaneous push and pop when non-full: count unchanged.
- Overrun flag: clr_overrun clears it. A set event in the same cycle as clr_overrun wins (set).
- reset asserted mid-frame: FSM and FIFO clear immediately. The next frame requires a fresh falling edge.
- Latency: an entry is visible (fifo_empty=0) 1 clk after the final stop-bit decision tick.

Decomposition:
- Package uart_rx_pkg holds:
  - rx_state_t with 3-bit encodings IDLE..WAIT_IDLE;
  - the sample-position constants derived from OVERSAMPLE.
- Sub-module uart_rx_fifo: generic synchronous FWFT FIFO with parameters WIDTH and DEPTH, and ports push, pop, full, empty, count.
- Tick generator, synchroniser and FSM remain in uart_rx_param.

Test Plan (OVERSAMPLE=16, baud_div=3, so 64 clk per bit; FIFO_DEPTH=4):
- 8N1 frame 0xA5 -> fifo_empty falls, rd_data=0xA5, rd_perr=0, rd_ferr=0, fifo_count=1. Then rd_en for 1 clk -> fifo_empty=1.
- parity_en=1, parity_odd=0, data 0x07 sent with parity bit 0 -> rd_data=0x07, rd_perr=1. Repeat with parity bit 1 -> rd_perr=0.
- rx_in held low for 12 clk, then high -> state returns to IDLE, no FIFO write, fifo_count stays 0.
- Line held low for 12 bit times -> entry 0x00 with rd_ferr=1, a single break_det pulse, state=5 until the line returns high, then state=0.
- Five frames 0x11, 0x22, 0x33, 0x44, 0x55 with no reads -> fifo_full=1, overrun=1, pops return 0x11..0x44. Then clr_overrun -> overrun=0.
- stop2=1 with the second stop bit driven 0, and reset pulsed for 1 clk at mid-DATA of a later frame:
  - first frame -> rd_ferr=1;
  - after the reset pulse -> fifo_empty=1, state=0;
  - a following clean 0x3C frame -> received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receive path.
// Holds the receive-FSM state encoding and helpers that turn the
// oversample ratio into the three majority-vote sample positions.
package uart_rx_pkg;

  // FSM states; encodings are driven straight onto the debug state port
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;

  // Sample positions inside a bit, centred on the middle tick
  function automatic int sampleLo(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int sampleMid(input int os);
    return os / 2;
  endfunction

  // The vote is decided on this tick
  function automatic int sampleHi(input int os);
    return os / 2 + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   push, wr_data   write request and entry
//   pop             read request, ignored when empty
//   rd_data         head entry (zero when empty)
//   full, empty     status flags
//   count           occupancy, 0..DEPTH
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A pop frees the slot a same-cycle push needs, so push-when-full is
  // accepted only alongside a real pop.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Head entry is read straight from the registered read pointer
  assign rd_data = empty ? '0 : mem_q[rdPtr_q];

  // Storage array carries no reset; entries are only observed when valid
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: baud tick generator, 2-FF synchroniser,
// majority-vote oversampling FSM and a FWFT FIFO of {ferr, perr, data}.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   baud_div                     clk cycles per oversample tick minus 1
//   rx_in                        serial line, idle high
//   parity_en, parity_odd, stop2 frame format, latched per frame
//   rd_en, clr_overrun           FIFO pop, overrun clear
//   rd_data, rd_perr, rd_ferr    FIFO head entry
//   fifo_empty/full/count        FIFO status
//   overrun                      sticky frame-dropped flag
//   break_det                    one-clk break pulse
//   state                        FSM state for debug
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          rx_in,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic                          rd_en,
  input  logic                          clr_overrun,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          break_det,
  output logic [2:0]                    state
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [SCW-1:0] SMP_LO   = SCW'(sampleLo(OVERSAMPLE));
  localparam logic [SCW-1:0] SMP_MID  = SCW'(sampleMid(OVERSAMPLE));
  localparam logic [SCW-1:0] SMP_HI   = SCW'(sampleHi(OVERSAMPLE));
  localparam logic [SCW-1:0] SUB_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  logic [DIV_W-1:0]     divCnt_q, divLim_q;
  logic                 tick;
  logic                 sync1_q, sync2_q, rxs;
  rx_state_t            state_q;
  logic [SCW-1:0]       subCnt_q;
  logic [BCW-1:0]       bitCnt_q;
  logic [DATA_BITS-1:0] dataSh_q;
  logic                 s0_q, s1_q, perr_q, ferr_q;
  logic                 parEn_q, parOdd_q, stop2_q;
  logic                 break_q, overrun_q;
  logic                 voted, lastStop, frameDone, frameFerr;
  logic [DATA_BITS+1:0] wrEntry, rdEntry;

  // Divisor is reloaded only at wrap so a mid-period change never
  // produces a short or skipped tick.
  assign tick = (divCnt_q == divLim_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt_q <= '0;
      divLim_q <= '0;
    end else if (tick) begin
      divCnt_q <= '0;
      divLim_q <= baud_div;
    end else begin
      divCnt_q <= divCnt_q + DIV_W'(1);
    end
  end

  // Flops preset to the idle level so reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // Third sample is the live line value on the decision tick
  assign voted     = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  assign lastStop  = stop2_q ? (bitCnt_q == BCW'(1)) : (bitCnt_q == '0);
  assign frameDone = tick && (state_q == STOP) && (subCnt_q == SMP_HI) && lastStop;
  assign frameFerr = ferr_q | ~voted;
  assign wrEntry   = {frameFerr, perr_q, dataSh_q};

  // Receive FSM; every transition is qualified by the oversample tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      subCnt_q <= '0;
      bitCnt_q <= '0;
      dataSh_q <= '0;
      s0_q     <= 1'b1;
      s1_q     <= 1'b1;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      parEn_q  <= 1'b0;
      parOdd_q <= 1'b0;
      stop2_q  <= 1'b0;
      break_q  <= 1'b0;
    end else begin
      break_q <= 1'b0;
      if (tick) begin
        subCnt_q <= (subCnt_q == SUB_LAST) ? '0 : subCnt_q + SCW'(1);
        if (subCnt_q == SMP_LO)  s0_q <= rxs;
        if (subCnt_q == SMP_MID) s1_q <= rxs;
        case (state_q)
          IDLE: begin
            // The detecting tick counts as sub-count 0 of the start bit
            subCnt_q <= SCW'(1);
            if (!rxs) state_q <= START;
          end
          START: begin
            if (subCnt_q == SMP_HI && voted) begin
              state_q <= IDLE;
            end else if (subCnt_q == SUB_LAST) begin
              state_q  <= DATA;
              bitCnt_q <= '0;
              perr_q   <= 1'b0;
              ferr_q   <= 1'b0;
              parEn_q  <= parity_en;
              parOdd_q <= parity_odd;
              stop2_q  <= stop2;
            end
          end
          DATA: begin
            if (subCnt_q == SMP_HI) dataSh_q <= {voted, dataSh_q[DATA_BITS-1:1]};
            if (subCnt_q == SUB_LAST) begin
              if (bitCnt_q == BIT_LAST) begin
                bitCnt_q <= '0;
                state_q  <= parEn_q ? PARITY : STOP;
              end else begin
                bitCnt_q <= bitCnt_q + BCW'(1);
              end
            end
          end
          PARITY: begin
            if (subCnt_q == SMP_HI) perr_q <= parEn_q & (voted != (^dataSh_q ^ parOdd_q));
            if (subCnt_q == SUB_LAST) state_q <= STOP;
          end
          STOP: begin
            if (subCnt_q == SMP_HI) begin
              if (lastStop) begin
                state_q <= frameFerr ? WAIT_IDLE : IDLE;
                break_q <= frameFerr && (dataSh_q == '0);
              end else if (!voted) begin
                ferr_q <= 1'b1;
              end
            end
            if (subCnt_q == SUB_LAST) bitCnt_q <= bitCnt_q + BCW'(1);
          end
          WAIT_IDLE: begin
            if (rxs) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Set wins over clear; a drop needs full with no pop freeing a slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (frameDone && fifo_full && !rd_en) begin
      overrun_q <= 1'b1;
    end else if (clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .reset   (reset),
    .push    (frameDone),
    .wr_data (wrEntry),
    .pop     (rd_en),
    .rd_data (rdEntry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rd_data   = rdEntry[DATA_BITS-1:0];
  assign rd_perr   = rdEntry[DATA_BITS];
  assign rd_ferr   = rdEntry[DATA_BITS+1];
  assign overrun   = overrun_q;
  assign break_det = break_q;
  assign state     = state_q;

endmodule
